mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/HI/LO width; even, >=8.
REQ-002 SHALL have port clk_in, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port start_in, input, 1: request one operation; sampled only in IDLE.
REQ-005 SHALL have port op_in, input, 2: operation select; 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have ports A_in and B_in, input, WIDTH: rs (multiplicand/dividend) and rt (multiplier/divisor).
REQ-007 SHALL have ports mthi_in and mtlo_in, input, 1 each: write A_in into HI or LO.
REQ-008 SHALL have port busy_out, output, 1: high in every state except IDLE.
REQ-009 SHALL have port done_out, output, 1: one-cycle pulse when HI/LO hold a new result.
REQ-010 SHALL have ports HI_out and LO_out, output, WIDTH: architectural HI/LO registers.

Function
REQ-011 SHALL implement FSM IDLE -> RUN -> FIX -> DONE -> IDLE.
REQ-012 SHALL leave IDLE for RUN on the edge where start_in=1 in IDLE, latching op_in, A_in, B_in.
REQ-013 SHALL stay in RUN exactly WIDTH cycles, one bit per cycle: radix-2 shift-add for multiply, restoring shift-subtract for divide.
REQ-014 SHALL use FIX (1 cycle) to apply sign correction: signed ops work on magnitudes; product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign.
REQ-015 SHALL write HI/LO on the edge entering DONE and assert done_out for the DONE cycle only; done_out high WIDTH+2 cycles after start edge.
REQ-016 SHALL place multiply result as HI = upper WIDTH bits, LO = lower WIDTH bits of 2*WIDTH product.
REQ-017 SHALL place divide result as LO = quotient, HI = remainder.
REQ-018 SHALL, on divide by zero, give LO = all ones, HI = A_in, with full normal latency.
REQ-019 SHALL, on DIV of most-negative by -1, give LO = most-negative, HI = 0.
REQ-020 SHALL ignore start_in, mthi_in, mtlo_in whenever busy_out=1.
REQ-021 SHALL, in IDLE, write A_in to HI (mthi_in) or LO (mtlo_in) on the next edge; both high writes both.
REQ-022 SHALL give start_in priority over mthi_in/mtlo_in when both are high in IDLE; the move is dropped.
REQ-023 SHALL keep HI_out/LO_out stable during RUN and FIX (old values visible until DONE).

Reset
REQ-024 SHALL on rst_in=1 immediately force state IDLE, HI_out=0, LO_out=0, busy_out=0, done_out=0, independent of clk_in.
REQ-025 SHALL, on reset mid-operation, discard the operation; no done_out follows after reset release.

Configuration
REQ-026 SHALL compile divide support only when macro MUL_DIV_UNIT_DIV_EN is defined.
REQ-027 SHALL, without MUL_DIV_UNIT_DIV_EN, treat op_in 10/11 with start_in as no-op: stay IDLE, no busy, no done_out, HI/LO unchanged; multiply unaffected.

Structure
REQ-028 SHALL take op encodings (MULTU, MULT, DIVU, DIV) and FSM state encodings from shared package mdu_pkg.
REQ-029 SHALL put the per-cycle add/subtract datapath (WIDTH+1-bit adder with carry/borrow out) in sub-module mdu_step; FSM, counter, registers in mul_div_unit.

Verification (WIDTH=32)
REQ-030 SHALL check MULT A=0xFFFFFFFF(-1), B=0x00000002 -> done_out at cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 SHALL check DIV A=0xFFFFFFF9(-7), B=0x00000002 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1); DIVU 100/7 -> LO=14, HI=2.
REQ-032 SHALL check DIVU A=0x12345678, B=0 -> LO=0xFFFFFFFF, HI=0x12345678; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 SHALL check start_in and mthi_in pulsed during RUN -> ignored; mthi_in with A=0xDEADBEEF in IDLE -> HI_out=0xDEADBEEF next cycle, LO unchanged.
REQ-034 SHALL check rst_in asserted at RUN cycle 10 of a MULTU -> outputs 0 immediately, no done_out in following 40 cycles.
REQ-035 SHALL check, with MUL_DIV_UNIT_DIV_EN undefined, DIVU start -> busy_out stays 0, no done_out, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: operation and FSM state encodings shared by the HI/LO
// multiply/divide unit and anything that observes it.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/response bundle of the HI/LO multiply/divide unit.
// start is taken on a rising edge only while busy is low; busy then stays high
// until done pulses for exactly one cycle with the new hi/lo already visible.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, mthi, mtlo, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, mthi, mtlo, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_step.sv
// mdu_step: WIDTH+1-bit add/subtract used once per iteration; cout_o is the
// carry for an add and the no-borrow flag (a_i >= b_i) for a subtract.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  input  logic           sub_i,
  output logic [WIDTH:0] res_o,
  output logic           cout_o
);
  logic [WIDTH+1:0] sum;

  assign sum    = {1'b0, a_i} + {1'b0, (sub_i ? ~b_i : b_i)} + {{(WIDTH+1){1'b0}}, sub_i};
  assign res_o  = sum[WIDTH:0];
  assign cout_o = sum[WIDTH+1];
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative HI/LO multiply/divide unit (one bit per cycle).
// Divide support is compiled in only when MUL_DIV_UNIT_DIV_EN is defined.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             mthi_in,
  input  logic             mtlo_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out,
  output state_e           dbg_state_out
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  op_e                op_in_e;
  logic               in_signed, a_neg, b_neg, accept;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     step_a, step_b, step_res, mul_sum;
  logic               step_sub, step_cout;
  logic [2*WIDTH-1:0] prod;

  assign op_in_e   = op_e'(op_in);
  assign in_signed = op_is_signed(op_in_e);
  assign a_neg     = in_signed & A_in[WIDTH-1];
  assign b_neg     = in_signed & B_in[WIDTH-1];
  assign mag_a     = a_neg ? -A_in : A_in;
  assign mag_b     = b_neg ? -B_in : B_in;
  assign mul_sum   = acc_lo_q[0] ? step_res : {1'b0, acc_hi_q};
  assign prod      = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

`ifdef MUL_DIV_UNIT_DIV_EN
  assign accept = start_in;
`else
  // A divide request still wins over a pending move, but starts nothing.
  assign accept = start_in & ~op_is_div(op_in_e);
  logic unused_div_state;
  assign unused_div_state = ^{a_q, neg_rem_q, op_q, step_cout};
`endif

  always_comb begin
    step_a   = {1'b0, acc_hi_q};
    step_b   = {1'b0, m_q};
    step_sub = 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
    if (op_is_div(op_q)) begin
      step_a   = {acc_hi_q, acc_lo_q[WIDTH-1]};
      step_sub = 1'b1;
    end
`endif
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .a_i   (step_a),
    .b_i   (step_b),
    .sub_i (step_sub),
    .res_o (step_res),
    .cout_o(step_cout)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    m_d       = m_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          if (accept) begin
            state_d   = ST_RUN;
            op_d      = op_in_e;
            a_d       = A_in;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = '0;
            acc_hi_d  = '0;
            // m holds the operand added/subtracted each step; acc_lo shifts.
            if (op_is_div(op_in_e)) begin
              m_d      = mag_b;
              acc_lo_d = mag_a;
            end else begin
              m_d      = mag_a;
              acc_lo_d = mag_b;
            end
          end
        end else begin
          if (mthi_in) hi_d = A_in;
          if (mtlo_in) lo_d = A_in;
        end
      end
      ST_RUN: begin
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef MUL_DIV_UNIT_DIV_EN
        if (op_is_div(op_q)) begin
          acc_hi_d = step_cout ? step_res[WIDTH-1:0] : step_a[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], step_cout};
        end
`endif
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) state_d = ST_FIX;
      end
      ST_FIX: begin
        hi_d = prod[2*WIDTH-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
`ifdef MUL_DIV_UNIT_DIV_EN
        if (op_is_div(op_q)) begin
          if (m_q == '0) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
            hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
          end
        end
`endif
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULTU;
      a_q       <= '0;
      m_q       <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      m_q       <= m_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy_out      = (state_q != ST_IDLE);
  assign done_out      = (state_q == ST_DONE);
  assign HI_out        = hi_q;
  assign LO_out        = lo_q;
  assign dbg_state_out = state_q;
endmodule
